// File: rtl/pipe_pkg.sv
// Shared opcode encodings, write-enable classification and stage-record types
// for the pipe_alu_hs datapath.
package pipe_pkg;

   localparam int FUNC_BITS = 4;

   localparam logic [FUNC_BITS-1:0] FUNC_ADD   = 4'd0;
   localparam logic [FUNC_BITS-1:0] FUNC_SUB   = 4'd1;
   localparam logic [FUNC_BITS-1:0] FUNC_MUL   = 4'd2;
   localparam logic [FUNC_BITS-1:0] FUNC_PASSA = 4'd3;
   localparam logic [FUNC_BITS-1:0] FUNC_PASSB = 4'd4;
   localparam logic [FUNC_BITS-1:0] FUNC_AND   = 4'd5;
   localparam logic [FUNC_BITS-1:0] FUNC_OR    = 4'd6;
   localparam logic [FUNC_BITS-1:0] FUNC_XOR   = 4'd7;
   localparam logic [FUNC_BITS-1:0] FUNC_NEGA  = 4'd8;
   localparam logic [FUNC_BITS-1:0] FUNC_NEGB  = 4'd9;
   localparam logic [FUNC_BITS-1:0] FUNC_SHR1  = 4'd10;
   localparam logic [FUNC_BITS-1:0] FUNC_SHL1  = 4'd11;
   localparam logic [FUNC_BITS-1:0] FUNC_LDI   = 4'd12;
   // opcodes from here up to 15 are illegal
   localparam logic [FUNC_BITS-1:0] FUNC_ILL_LO = 4'd13;

   function automatic logic is_illegal(input logic [FUNC_BITS-1:0] f);
      return f >= FUNC_ILL_LO;
   endfunction

   function automatic logic writes_reg(input logic [FUNC_BITS-1:0] f);
      return !is_illegal(f);
   endfunction

   function automatic logic writes_mem(input logic [FUNC_BITS-1:0] f);
      return !is_illegal(f) && (f != FUNC_LDI);
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [FUNC_BITS-1:0] func;
   } issue_t;

   typedef struct packed {
      logic valid;
      logic wr_reg;
      logic wr_mem;
      logic err;
   } result_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational execute unit: opcode and operands to result plus illegal-op flag.
module pipe_alu
   import pipe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int MEM_AW = 8
) (
   input  logic [FUNC_BITS-1:0] func,
   input  logic [DATA_W-1:0]    a,
   input  logic [DATA_W-1:0]    b,
   input  logic [MEM_AW-1:0]    imm,
   output logic [DATA_W-1:0]    z,
   output logic                 err
);

   always_comb begin
      z   = '0;
      err = 1'b0;
      case (func)
         FUNC_ADD:   z = a + b;
         FUNC_SUB:   z = a - b;
         FUNC_MUL:   z = a * b;
         FUNC_PASSA: z = a;
         FUNC_PASSB: z = b;
         FUNC_AND:   z = a & b;
         FUNC_OR:    z = a | b;
         FUNC_XOR:   z = a ^ b;
         FUNC_NEGA:  z = -a;
         FUNC_NEGB:  z = -b;
         FUNC_SHR1:  z = a >> 1;
         FUNC_SHL1:  z = a << 1;
         FUNC_LDI:   z = DATA_W'(imm);
         default:    err = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_alu_hs.sv
// 4-stage register-to-register ALU pipeline with valid/ready handshakes.
// Define PIPE_FWD_EN for RAW forwarding; otherwise dependent issues stall.
module pipe_alu_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int MEM_AW = 8,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic [FUNC_W-1:0] func,
   input  logic [MEM_AW-1:0] addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_z,
   output logic [REG_AW-1:0] out_rd,
   output logic [MEM_AW-1:0] out_addr,
   output logic              out_err,
   input  logic [MEM_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_mem,
   output logic [DATA_W-1:0] dbg_reg
);

   localparam int NREG = 2**REG_AW;
   localparam int NMEM = 2**MEM_AW;

   issue_t            l12;
   logic [DATA_W-1:0] a12, b12;
   logic [REG_AW-1:0] rd12;
   logic [MEM_AW-1:0] addr12;

   result_t           l23;
   logic [DATA_W-1:0] z23;
   logic [REG_AW-1:0] rd23;
   logic [MEM_AW-1:0] addr23;

   logic              v34, wmem34, err34;
   logic [DATA_W-1:0] z34;
   logic [REG_AW-1:0] rd34;
   logic [MEM_AW-1:0] addr34;

   logic [DATA_W-1:0] regbank [NREG];
   logic [DATA_W-1:0] mem     [NMEM];

   logic              advance, hazard, accept;
   logic [DATA_W-1:0] opa, opb, alu_z;
   logic              alu_err;

   assign advance = !v34 || out_ready;
   assign in_ready = advance && !hazard;
   assign accept = in_valid && in_ready;

   pipe_alu #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_alu (
      .func (l12.func),
      .a    (a12),
      .b    (b12),
      .imm  (addr12),
      .z    (alu_z),
      .err  (alu_err)
   );

`ifdef PIPE_FWD_EN
   // Younger producer (still in S2) wins over the one about to write back.
   always_comb begin
      opa = regbank[rs1];
      opb = regbank[rs2];
      if (l23.valid && l23.wr_reg && (rd23 == rs1)) opa = z23;
      if (l23.valid && l23.wr_reg && (rd23 == rs2)) opb = z23;
      if (l12.valid && writes_reg(l12.func) && (rd12 == rs1)) opa = alu_z;
      if (l12.valid && writes_reg(l12.func) && (rd12 == rs2)) opb = alu_z;
   end
   assign hazard = 1'b0;
`else
   always_comb begin
      opa = regbank[rs1];
      opb = regbank[rs2];
   end
   assign hazard = in_valid &&
      ((l12.valid && writes_reg(l12.func) && ((rd12 == rs1) || (rd12 == rs2))) ||
       (l23.valid && l23.wr_reg && ((rd23 == rs1) || (rd23 == rs2))));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l12    <= '0;
         a12    <= '0;
         b12    <= '0;
         rd12   <= '0;
         addr12 <= '0;
         l23    <= '0;
         z23    <= '0;
         rd23   <= '0;
         addr23 <= '0;
         v34    <= 1'b0;
         wmem34 <= 1'b0;
         err34  <= 1'b0;
         z34    <= '0;
         rd34   <= '0;
         addr34 <= '0;
         for (int i = 0; i < NREG; i++) regbank[i] <= '0;
      end else if (advance) begin
         l12.valid <= accept;
         if (accept) begin
            l12.func <= func;
            a12      <= opa;
            b12      <= opb;
            rd12     <= rd;
            addr12   <= addr;
         end else begin
            l12.func <= '0;
            a12      <= '0;
            b12      <= '0;
            rd12     <= '0;
            addr12   <= '0;
         end

         l23.valid  <= l12.valid;
         l23.wr_reg <= l12.valid && writes_reg(l12.func);
         l23.wr_mem <= l12.valid && writes_mem(l12.func);
         l23.err    <= l12.valid && alu_err;
         z23        <= alu_z;
         rd23       <= rd12;
         addr23     <= addr12;

         v34    <= l23.valid;
         wmem34 <= l23.wr_mem;
         err34  <= l23.err;
         z34    <= z23;
         rd34   <= rd23;
         addr34 <= addr23;

         if (l23.valid && l23.wr_reg) regbank[rd23] <= z23;
      end
   end

   // Data memory is deliberately left unreset; stores happen on the output handshake.
   always_ff @(posedge clk) begin
      if (v34 && out_ready && wmem34) mem[addr34] <= z34;
   end

   assign out_valid = v34;
   assign out_z     = z34;
   assign out_rd    = rd34;
   assign out_addr  = addr34;
   assign out_err   = err34;
   assign dbg_mem   = mem[dbg_raddr];
   assign dbg_reg   = regbank[dbg_raddr[REG_AW-1:0]];

endmodule

// File: tb/tb_pipe_alu_hs.sv
// Directed self-checking bench for pipe_alu_hs (both PIPE_FWD_EN builds).
`timescale 1ns/1ps
module tb_pipe_alu_hs;
   import pipe_pkg::*;

   localparam int DW = 16;
   localparam int RW = 4;
   localparam int MW = 8;
`ifdef PIPE_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, out_valid, out_ready, out_err;
   logic [RW-1:0] rs1, rs2, rd, out_rd;
   logic [3:0]    func;
   logic [MW-1:0] addr, out_addr, dbg_raddr;
   logic [DW-1:0] out_z, dbg_mem, dbg_reg;

   always #5 clk = ~clk;

   pipe_alu_hs #(.DATA_W(DW), .REG_AW(RW), .MEM_AW(MW), .FUNC_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_rd(out_rd),
      .out_addr(out_addr), .out_err(out_err), .dbg_raddr(dbg_raddr),
      .dbg_mem(dbg_mem), .dbg_reg(dbg_reg)
   );

   int n_vec = 0;
   int n_err = 0;
   int ncyc  = 0;

   typedef struct {
      logic [DW-1:0] z;
      logic [RW-1:0] rd;
      logic [MW-1:0] addr;
      logic          err;
      int            cyc;
   } obs_t;
   obs_t q[$];

   always @(negedge clk) ncyc++;

   // Record every output handshake, well clear of the rising edge.
   always @(negedge clk) begin
      #2;
      if (out_valid && out_ready) q.push_back('{out_z, out_rd, out_addr, out_err, ncyc});
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] f, input logic [RW-1:0] d, input logic [RW-1:0] s1,
                        input logic [RW-1:0] s2, input logic [MW-1:0] a, output int stalls);
      func = f; rd = d; rs1 = s1; rs2 = s2; addr = a; in_valid = 1'b1;
      stalls = 0;
      #1;
      while (!in_ready && stalls < 20) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (!in_ready) check("issue_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic expect_out(input string tag, input logic [DW-1:0] z, input logic [RW-1:0] d,
                             input logic [MW-1:0] a, input logic e, output int cyc);
      obs_t o;
      o = '{z: '0, rd: '0, addr: '0, err: 1'b0, cyc: -1};
      if (q.size() > 0) o = q.pop_front();
      check({tag, "_z"}, o.z, z);
      check({tag, "_rd"}, o.rd, d);
      check({tag, "_addr"}, o.addr, a);
      check({tag, "_err"}, o.err, e);
      cyc = o.cyc;
   endtask

   task automatic chk_mem(input string tag, input logic [MW-1:0] a, input logic [DW-1:0] exp);
      @(negedge clk);
      dbg_raddr = a;
      #1;
      check(tag, dbg_mem, exp);
   endtask

   task automatic chk_reg(input string tag, input logic [RW-1:0] r, input logic [DW-1:0] exp);
      @(negedge clk);
      dbg_raddr = MW'(r);
      #1;
      check(tag, dbg_reg, exp);
   endtask

   initial begin
      int st, c0, c1, c2, c3, c4, bad;
      in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
      out_ready = 1'b1; dbg_raddr = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_z", out_z, 0);
      check("rst_out_err", out_err, 0);
      check("rst_dbg_reg0", dbg_reg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: back-to-back LDI, LDI, dependent ADD
      issue(FUNC_LDI, 4'd1, 4'd0, 4'd0, 8'd5, st);  check("t1_ldi1_stall", st, 0);
      issue(FUNC_LDI, 4'd2, 4'd0, 4'd0, 8'd3, st);  check("t1_ldi2_stall", st, 0);
      issue(FUNC_ADD, 4'd3, 4'd1, 4'd2, 8'h10, st); check("t1_add_stall", st, FWD ? 0 : 2);
      drain(5);
      check("t1_count", q.size(), 3);
      expect_out("t1_o0", 16'd5, 4'd1, 8'd5, 1'b0, c0);
      expect_out("t1_o1", 16'd3, 4'd2, 8'd3, 1'b0, c1);
      expect_out("t1_o2", 16'd8, 4'd3, 8'h10, 1'b0, c2);
      check("t1_gap1", c1 - c0, 1);
      check("t1_gap2", c2 - c1, FWD ? 1 : 3);
      chk_mem("t1_mem10", 8'h10, 16'd8);
      chk_reg("t1_r3", 4'd3, 16'd8);

      // 2: MUL / SUB / SHL1 arithmetic with wrap-around
      issue(FUNC_LDI, 4'd1, 4'd0, 4'd0, 8'h80, st);  check("t2_ldi_stall", st, 0);
      issue(FUNC_MUL, 4'd4, 4'd1, 4'd1, 8'h11, st);  check("t2_mul_stall", st, FWD ? 0 : 2);
      issue(FUNC_SUB, 4'd5, 4'd0, 4'd1, 8'h12, st);  check("t2_sub_stall", st, 0);
      issue(FUNC_SHL1, 4'd6, 4'd4, 4'd0, 8'h13, st); check("t2_shl_stall", st, FWD ? 0 : 1);
      drain(5);
      check("t2_count", q.size(), 4);
      expect_out("t2_o0", 16'h0080, 4'd1, 8'h80, 1'b0, c0);
      expect_out("t2_o1", 16'h4000, 4'd4, 8'h11, 1'b0, c0);
      expect_out("t2_o2", 16'hFF80, 4'd5, 8'h12, 1'b0, c0);
      expect_out("t2_o3", 16'h8000, 4'd6, 8'h13, 1'b0, c0);
      chk_mem("t2_mem11", 8'h11, 16'h4000);
      chk_mem("t2_mem13", 8'h13, 16'h8000);
      chk_reg("t2_r6", 4'd6, 16'h8000);

      // 3: three in flight, output stalled for 4 cycles
      issue(FUNC_LDI, 4'd8, 4'd0, 4'd0, 8'h21, st);
      issue(FUNC_LDI, 4'd9, 4'd0, 4'd0, 8'h22, st);
      issue(FUNC_ADD, 4'd10, 4'd4, 4'd5, 8'h30, st);
      out_ready = 1'b0;
      dbg_raddr = 8'd9;
      #1;
      check("t3_in_ready", in_ready, 0);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_z !== 16'h21 ||
             out_addr !== 8'h21 || dbg_reg !== 16'h0) bad++;
         @(negedge clk);
         #1;
      end
      check("t3_frozen", bad, 0);
      check("t3_none_out", q.size(), 0);
      out_ready = 1'b1;
      drain(5);
      check("t3_count", q.size(), 3);
      expect_out("t3_o0", 16'h0021, 4'd8, 8'h21, 1'b0, c0);
      expect_out("t3_o1", 16'h0022, 4'd9, 8'h22, 1'b0, c1);
      expect_out("t3_o2", 16'h3F80, 4'd10, 8'h30, 1'b0, c2);
      check("t3_gap", c2 - c0, 2);
      chk_mem("t3_mem30", 8'h30, 16'h3F80);

      // 4: illegal opcodes and LDI must not disturb regbank / mem
      issue(FUNC_ADD, 4'd11, 4'd1, 4'd0, 8'h20, st);
      issue(FUNC_LDI, 4'd2, 4'd0, 4'd0, 8'h07, st);
      issue(4'd14, 4'd2, 4'd1, 4'd2, 8'h20, st); check("t4_ill_stall", st, FWD ? 0 : 2);
      issue(4'd13, 4'd11, 4'd0, 4'd0, 8'h20, st);
      issue(FUNC_LDI, 4'd7, 4'd0, 4'd0, 8'h10, st);
      drain(5);
      check("t4_count", q.size(), 5);
      expect_out("t4_o0", 16'h0080, 4'd11, 8'h20, 1'b0, c0);
      expect_out("t4_o1", 16'h0007, 4'd2, 8'h07, 1'b0, c1);
      expect_out("t4_o2", 16'h0000, 4'd2, 8'h20, 1'b1, c2);
      expect_out("t4_o3", 16'h0000, 4'd11, 8'h20, 1'b1, c3);
      expect_out("t4_o4", 16'h0010, 4'd7, 8'h10, 1'b0, c4);
      chk_reg("t4_r2", 4'd2, 16'h0007);
      chk_reg("t4_r11", 4'd11, 16'h0080);
      chk_reg("t4_r7", 4'd7, 16'h0010);
      chk_mem("t4_mem20", 8'h20, 16'h0080);
      chk_mem("t4_mem10", 8'h10, 16'h0008);

      // 5: reset with two instructions in flight
      issue(FUNC_ADD, 4'd12, 4'd1, 4'd2, 8'h10, st);
      issue(FUNC_SUB, 4'd13, 4'd1, 4'd2, 8'h20, st);
      @(negedge clk);
      check("t5_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("t5_valid_drop", out_valid, 0);
      check("t5_z_clear", out_z, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drain(4);
      check("t5_count", q.size(), 0);
      for (int r = 0; r < 16; r++) chk_reg($sformatf("t5_r%0d", r), RW'(r), 16'h0);
      chk_mem("t5_mem10", 8'h10, 16'h0008);
      chk_mem("t5_mem20", 8'h20, 16'h0080);

      // 6: immediate dependency, stall count depends on build
      @(negedge clk);
      issue(FUNC_LDI, 4'd1, 4'd0, 4'd0, 8'd9, st);  check("t6_ldi_stall", st, 0);
      issue(FUNC_ADD, 4'd2, 4'd1, 4'd1, 8'h50, st); check("t6_add_stall", st, FWD ? 0 : 2);
      drain(5);
      check("t6_count", q.size(), 2);
      expect_out("t6_o0", 16'd9, 4'd1, 8'd9, 1'b0, c0);
      expect_out("t6_o1", 16'd18, 4'd2, 8'h50, 1'b0, c1);
      chk_mem("t6_mem50", 8'h50, 16'd18);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_alu_hs.md
Name: pipe_alu_hs

Overview:
Parametrised 4-stage register-to-register ALU pipeline: operand read, execute, register writeback, memory store.
- Successor to the fixed 16-bit two-phase-clock pipeline.
- Single clock; valid/ready handshakes at input and output.
- Full RAW operand forwarding; immediate-load op; illegal-op flagging.
- Sits between the instruction issue logic and the data memory; includes a debug read port for the register bank and data memory.

Parameters:
DATA_W, 16, datapath / register / memory word width
REG_AW, 4, register-index width (2**REG_AW registers)
MEM_AW, 8, data-memory address width (2**MEM_AW words); must be <= DATA_W
FUNC_W, 4, opcode width (fixed 4, opcodes 0-15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid&&in_ready at edge
rs1  in  REG_AW  source A register index
rs2  in  REG_AW  source B register index
rd  in  REG_AW  destination register index
func  in  FUNC_W  opcode
addr  in  MEM_AW  store address; also immediate for LDI
out_valid  out  1  result present in final stage
out_ready  in  1  consumer accepts result
out_z  out  DATA_W  result
out_rd  out  REG_AW  destination of result
out_addr  out  MEM_AW  store address of result
out_err  out  1  result came from an illegal opcode
dbg_raddr  in  MEM_AW  debug read address, combinational read
dbg_mem  out  DATA_W  mem[dbg_raddr]
dbg_reg  out  DATA_W  regbank[dbg_raddr[REG_AW-1:0]]

Behaviour:
Clocking and reset:
- One clock; async reset only; no X values ever driven.

Stages:
- S1 captures operands, rd, func, addr and valid into L12.
- S2 computes the ALU result into L23.
- S3 writes regbank[L23_rd] and loads L34.
- Output handshake (out_valid&&out_ready) writes mem[L34_addr] <= L34_Z.

Pipeline advance:
- advance = !out_valid || out_ready.
- When advance=0, the whole pipe freezes: no stage register, regbank or mem changes; outputs stay stable.
- in_ready = advance (and, in the no-forwarding build, no hazard).

Latency:
- Instruction accepted at edge k: out_valid=1 after edge k+2 (with no stalls).
- Throughput: 1 instruction per cycle.

Opcodes (result width DATA_W, arithmetic modulo 2**DATA_W):
- 0 ADD, 1 SUB, 2 MUL (low DATA_W bits), 3 PASSA, 4 PASSB, 5 AND, 6 OR, 7 XOR.
- 8 NEGA, 9 NEGB (two's complement).
- 10 SHR1 A, 11 SHL1 A (logical, zero fill).
- 12 LDI: Z = zero-extended addr; no memory store.
- 13-15 illegal: Z = 0, err = 1, no regbank write, no memory store.

Write enables:
- Regbank written only for valid, non-illegal entries.
- Memory written only for valid, non-illegal, non-LDI entries.

Forwarding (S1 operand capture):
- Priority: S2 ALU result (valid L12, L12_rd match, writing op) > L23_Z (valid L23, writing op) > regbank.
- Applied independently to rs1 and rs2.

Reset values:
- All valid bits 0; L12/L23/L34 data 0; regbank all 0; out_z/out_rd/out_addr/out_err 0; out_valid 0.
- in_ready follows advance and is 1 during reset.
- mem is not reset.

Reset mid-operation:
- In-flight instructions are discarded and perform no regbank or mem write.
- out_valid drops immediately (asynchronously).

Simultaneous events:
- S3 writeback and S1 read of the same register in the same cycle: the forwarded value is used.
- Output store and a new S3 writeback in the same edge are independent.

Optional Feature:
PIPE_FWD_EN
- Defined: forwarding as above; no hazard stalls.
- Undefined: forwarding logic is absent.
  - in_ready = advance && !hazard.
  - hazard = in_valid && (rs1 or rs2 equals rd of a valid writing op in L12 or L23).
  - A dependent instruction issued right after its producer stalls exactly 2 cycles.
  - Results are identical to the forwarding build.

Decomposition:
- Package pipe_pkg holds:
  - opcode localparams FUNC_ADD..FUNC_LDI and the illegal range;
  - the writes_reg/writes_mem classification functions;
  - the stage-record struct typedef, parametrised by width localparams.
- One natural sub-module: pipe_alu, the combinational opcode/operand-to-result+err unit, instantiated in S2.

Test Plan:
1. Reset; back-to-back LDI r1,5; LDI r2,3; ADD r3=r1+r2 addr 0x10; out_ready=1 -> in_ready stays 1; out_z 5,3,8 on consecutive cycles; dbg_mem[0x10]=8; dbg_reg[3]=8.
2. LDI r1,0x80; MUL r4=r1*r1; SUB r5=r0-r1; SHL1 r6=r4 -> out_z 0x4000, 0xFF80, 0x8000; with DATA_W=8 the MUL result is 0x00.
3. Three instructions in flight, out_ready=0 for 4 cycles -> in_ready=0; out_z/out_addr stable; exactly one mem write per instruction after release; order preserved.
4. func=14 rd=2 addr=0x20 with r2=7 -> out_err=1, out_z=0; dbg_reg[2] stays 7; mem[0x20] unchanged.
5. rst_n low for 1 cycle with 2 instructions in flight -> out_valid=0 at once; regbank all 0 afterwards; the targeted mem words are unchanged.
6. PIPE_FWD_EN undefined: LDI r1,9 then ADD r2=r1+r1 -> in_ready low exactly 2 cycles; out_z=18. PIPE_FWD_EN defined: 0 stall cycles, same result.
